// File: rtl/mealy_symbol_packer_pkg.sv
// Shared definitions for the Mealy symbol packer: default symbol width and
// packer FSM state encodings.
package mealy_symbol_packer_pkg;

    // Symbol width of the upstream Mealy detector output
    localparam int SYM_W_DEF = 2;

    // Packer states
    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } pk_state_e;

endpackage

// File: rtl/mealy_symbol_packer_sync_fifo.sv
// sync_fifo: small synchronous FIFO with a registered head entry.
// The head register always holds the oldest entry (or 0 when empty), so the
// consumer sees a flop output rather than a memory read path.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_next, rd_next;
    logic [WIDTH-1:0] head_q, head_next;
    logic             do_push, do_pop;

    // Extra pointer bit separates full (MSBs differ) from empty (all equal)
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign wr_next = wr_ptr + (AW+1)'(do_push);
    assign rd_next = rd_ptr + (AW+1)'(do_pop);
    assign dout    = head_q;

    // Next head: zero when empty, bypass the incoming word when it lands at the head
    always_comb begin
        head_next = mem[rd_next[AW-1:0]];
        if (wr_next == rd_next)
            head_next = '0;
        else if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0]))
            head_next = din;
    end

    // Storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointers and registered head
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            head_q <= head_next;
        end
    end

endmodule

// File: rtl/mealy_symbol_packer.sv
// mealy_symbol_packer: packs SYM_W-bit symbols LSB-first into words of
// SYMS_PER_WORD symbols and queues them for a valid/ready consumer.
// A completed word that finds the FIFO full waits in a pending register
// (STALL); symbols arriving meanwhile are dropped and flagged in overflow.
// Optional macro PACKER_PARITY_EN adds a per-entry even-parity output word_par.
module mealy_symbol_packer
    import mealy_symbol_packer_pkg::*;
#(
    parameter int SYM_W         = SYM_W_DEF,
    parameter int SYMS_PER_WORD = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [SYM_W-1:0]                       sym_in,
    input  logic                                   sym_valid,
    input  logic                                   flush,
    output logic [SYM_W*SYMS_PER_WORD-1:0]         word_out,
    output logic [$clog2(SYMS_PER_WORD+1)-1:0]     word_cnt,
    output logic                                   word_valid,
    input  logic                                   word_ready,
    output logic                                   overflow,
    input  logic                                   clr_ovf,
`ifdef PACKER_PARITY_EN
    output logic                                   word_par,
`endif
    output logic                                   busy
);

    localparam int WORD_W = SYM_W * SYMS_PER_WORD;
    localparam int CNT_W  = $clog2(SYMS_PER_WORD + 1);
`ifdef PACKER_PARITY_EN
    localparam int ENT_W  = WORD_W + CNT_W + 1;
`else
    localparam int ENT_W  = WORD_W + CNT_W;
`endif

    pk_state_e         state;
    logic [WORD_W-1:0] shift_reg, shift_with, pend_word, push_word;
    logic [CNT_W-1:0]  sym_cnt, cnt_with, pend_cnt, push_cnt;
    logic              accept, complete, pop_fire, room, push;
    logic              fifo_full, fifo_empty;
    logic [ENT_W-1:0]  fifo_din, fifo_dout;

    assign pop_fire = ~fifo_empty & word_ready;
    assign room     = ~fifo_full | pop_fire;
    assign accept   = (state == COLLECT) & sym_valid;
    assign cnt_with = sym_cnt + CNT_W'(accept);

    // Word as it would look after including this cycle's symbol
    always_comb begin
        shift_with = shift_reg;
        if (accept)
            shift_with[sym_cnt*SYM_W +: SYM_W] = sym_in;
    end

    // Word closes on the last symbol, or on flush when it holds anything
    assign complete = (state == COLLECT) &
                      ((accept & (sym_cnt == CNT_W'(SYMS_PER_WORD - 1))) |
                       (flush & (cnt_with != '0)));

    // In STALL the FIFO is full, so a pop is the only way the pending word gets in
    assign push_word = (state == STALL) ? pend_word : shift_with;
    assign push_cnt  = (state == STALL) ? pend_cnt  : cnt_with;
    assign push      = (state == STALL) ? pop_fire  : (complete & room);

`ifdef PACKER_PARITY_EN
    assign fifo_din = {^push_word, push_cnt, push_word};
    assign word_par = fifo_dout[ENT_W-1];
`else
    assign fifo_din = {push_cnt, push_word};
`endif

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (word_ready),
        .din     (fifo_din),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dout    (fifo_dout)
    );

    assign word_out   = fifo_dout[WORD_W-1:0];
    assign word_cnt   = fifo_dout[WORD_W +: CNT_W];
    assign word_valid = ~fifo_empty;
    assign busy       = (sym_cnt != '0) | (state == STALL);

    // Packer FSM: symbol collection, pending-word stall and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= COLLECT;
            sym_cnt   <= '0;
            shift_reg <= '0;
            pend_word <= '0;
            pend_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            // A drop in the same cycle as a clear keeps the flag set
            if ((state == STALL) && sym_valid)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;

            case (state)
                COLLECT: begin
                    if (complete) begin
                        sym_cnt   <= '0;
                        shift_reg <= '0;
                        if (!room) begin
                            pend_word <= shift_with;
                            pend_cnt  <= cnt_with;
                            state     <= STALL;
                        end
                    end else if (accept) begin
                        shift_reg <= shift_with;
                        sym_cnt   <= cnt_with;
                    end
                end
                STALL: begin
                    if (pop_fire)
                        state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
